pc_redirect_unit: RTL and testbench
===================================

// Module: pc_redirect_unit
// PURPOSE
//   Fetch-stage PC register and the consumer of the decode-stage branch decision
//   (br_valid/br_taken from the comparator), jump targets, and CP0 exception/eret
//   redirects. Produces the F-stage PC every cycle and honours the MIPS branch
//   delay slot. Emits kill/delay-slot flags to the F/D register and keeps
//   taken-branch and redirect performance counters. Sits between the hazard
//   unit, the D-stage branch/jump logic and the instruction memory address port.
// PARAMETERS
//   RESET_PC  32'h0000_3000  PC loaded on reset
//   EXC_PC    32'h0000_4180  exception handler entry
//   PC_LO     32'h0000_3000  lowest legal fetch address
//   PC_HI     32'h0000_6ffc  highest legal fetch address
//   CNT_W     32             width of the performance counters
// PORTS
//   clk            in   1      rising-edge clock
//   reset          in   1      synchronous, active-high reset
//   stall          in   1      hazard unit freezes F and D this cycle
//   br_valid       in   1      D-stage instruction is a conditional branch
//   br_taken       in   1      comparator result for the D-stage branch
//   br_target      in   32     branch target (D-stage PC+4 + offset<<2)
//   jmp_valid      in   1      D-stage instruction is j/jal/jr/jalr
//   jmp_target     in   32     jump target
//   exc_req        in   1      CP0 takes an exception this cycle
//   eret_req       in   1      eret commits this cycle
//   epc            in   32     return address for eret
//   pc             out  32     current F-stage fetch address
//   kill_f         out  1      F-stage instruction must be flushed to a bubble
//   in_delay_slot  out  1      F-stage instruction is a branch/jump delay slot
//   addr_err       out  1      pc misaligned or outside [PC_LO, PC_HI]
//   br_taken_cnt   out  CNT_W  taken branches/jumps since reset
//   redirect_cnt   out  CNT_W  exception+eret redirects since reset
// BEHAVIOUR
//   - Reset: pc=RESET_PC, state=RUN, both counters 0; kill_f, in_delay_slot,
//     addr_err combinationally 0 while pc=RESET_PC and no exc/eret input.
//   - States: RUN (normal), REDIR (exactly one cycle after an exc/eret redirect,
//     D holds a flushed bubble so br_valid/jmp_valid are ignored).
//   - Next-pc priority at each edge (first match wins):
//     1 reset -> RESET_PC
//     2 exc_req -> EXC_PC, state->REDIR, redirect_cnt+1
//     3 eret_req -> epc, state->REDIR, redirect_cnt+1 (eret has no delay slot)
//     4 stall -> pc and state unchanged, counters unchanged
//     5 RUN & jmp_valid -> jmp_target, br_taken_cnt+1
//     6 RUN & br_valid & br_taken -> br_target, br_taken_cnt+1
//     7 otherwise -> pc+4 (mod 2^32), state->RUN
//   - exc_req and eret_req together: exception wins; counter increments once.
//   - exc/eret override stall; a stalled branch is re-evaluated every cycle until
//     stall drops (no latching of br_taken).
//   - Delay slot: when the branch/jump is in D, its delay slot is already in F;
//     redirect writes the target directly, so the slot executes. Not-taken
//     branch -> pc+4 normally.
//   - kill_f = exc_req | eret_req (combinational).
//   - in_delay_slot = (state==RUN) & (br_valid|jmp_valid) & ~kill_f.
//   - addr_err = (pc[1:0]!=0) | (pc<PC_LO) | (pc>PC_HI), unsigned compare, from
//     the pc register; no effect on sequencing (CP0 raises exc_req).
//   - Counters wrap at 2^CNT_W without saturation.
//   - Reset mid-operation (in REDIR, during stall, with redirect pending): all
//     state returns to reset values on that edge; inputs that cycle are dropped.
// TESTING
//   1 Reset 2 cycles, no events -> pc 0x3000, 0x3004, 0x3008; counters 0.
//   2 pc=0x3010, br_valid=1 br_taken=1 target=0x3040 -> next pc 0x3040,
//     in_delay_slot=1 that cycle, br_taken_cnt=1; br_taken=0 -> 0x3014, cnt same.
//   3 Branch taken with stall=1 for 3 cycles -> pc held at 0x3010 and cnt
//     unchanged; stall drops -> pc 0x3040, cnt+1 once.
//   4 exc_req with stall=1 and br taken -> pc 0x4180, kill_f=1, redirect_cnt=1;
//     next cycle (REDIR) br_valid=1 ignored -> pc 0x4184.
//   5 exc_req and eret_req same cycle, epc=0x3020 -> pc 0x4180, redirect_cnt+1;
//     eret alone -> pc 0x3020, in_delay_slot=0.
//   6 jmp_target=0x7000 -> addr_err=1; 0x3002 -> addr_err=1; reset mid-REDIR
//     -> pc 0x3000, counters 0, state RUN.

Source files
------------

// File: rtl/pc_redirect_unit_if.sv
// Bus between the fetch PC/redirect unit and its neighbours.
// The neighbours are the hazard unit, D-stage branch/jump logic, CP0 and the imem address port.
interface pc_redirect_unit_if #(
    parameter int unsigned CNT_W = 32
);
    logic             stall;
    logic             br_valid;
    logic             br_taken;
    logic [31:0]      br_target;
    logic             jmp_valid;
    logic [31:0]      jmp_target;
    logic             exc_req;
    logic             eret_req;
    logic [31:0]      epc;
    logic [31:0]      pc;
    logic             kill_f;
    logic             in_delay_slot;
    logic             addr_err;
    logic [CNT_W-1:0] br_taken_cnt;
    logic [CNT_W-1:0] redirect_cnt;

    modport master (
        output stall, br_valid, br_taken, br_target, jmp_valid, jmp_target,
               exc_req, eret_req, epc,
        input  pc, kill_f, in_delay_slot, addr_err, br_taken_cnt, redirect_cnt
    );

    modport slave (
        input  stall, br_valid, br_taken, br_target, jmp_valid, jmp_target,
               exc_req, eret_req, epc,
        output pc, kill_f, in_delay_slot, addr_err, br_taken_cnt, redirect_cnt
    );
endinterface

// File: rtl/pc_redirect_unit.sv
// Fetch-stage PC register with branch/jump/exception/eret redirection.
// It honours the MIPS delay slot and keeps taken-branch and redirect counters.
module pc_redirect_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] EXC_PC   = 32'h0000_4180,
    parameter logic [31:0] PC_LO    = 32'h0000_3000,
    parameter logic [31:0] PC_HI    = 32'h0000_6ffc,
    parameter int unsigned CNT_W    = 32
) (
    input  logic               clk,
    input  logic               reset,
    pc_redirect_unit_if.slave  bus
);
    localparam logic [0:0] RUN   = 1'b0;
    localparam logic [0:0] REDIR = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
    logic             kill;

    assign kill = bus.exc_req | bus.eret_req;

    // State, pc and counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= RUN;
            pc_q     <= RESET_PC;
            br_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            br_cnt_q <= br_cnt_d;
            rd_cnt_q <= rd_cnt_d;
        end
    end

    // Next-pc selection; exc/eret override stall, stalled branches re-evaluate each cycle
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        br_cnt_d = br_cnt_q;
        rd_cnt_d = rd_cnt_q;
        if (bus.exc_req) begin
            pc_d     = EXC_PC;
            state_d  = REDIR;
            rd_cnt_d = rd_cnt_q + CNT_W'(1);
        end else if (bus.eret_req) begin
            pc_d     = bus.epc;
            state_d  = REDIR;
            rd_cnt_d = rd_cnt_q + CNT_W'(1);
        end else if (bus.stall) begin
            pc_d    = pc_q;
            state_d = state_q;
        end else if ((state_q == RUN) && bus.jmp_valid) begin
            pc_d     = bus.jmp_target;
            br_cnt_d = br_cnt_q + CNT_W'(1);
        end else if ((state_q == RUN) && bus.br_valid && bus.br_taken) begin
            pc_d     = bus.br_target;
            br_cnt_d = br_cnt_q + CNT_W'(1);
        end else begin
            pc_d    = pc_q + 32'd4;
            state_d = RUN;
        end
    end

    assign bus.pc            = pc_q;
    assign bus.br_taken_cnt  = br_cnt_q;
    assign bus.redirect_cnt  = rd_cnt_q;
    assign bus.kill_f        = kill;
    assign bus.in_delay_slot = (state_q == RUN) & (bus.br_valid | bus.jmp_valid) & ~kill;
    assign bus.addr_err      = (pc_q[1:0] != 2'b00) | (pc_q < PC_LO) | (pc_q > PC_HI);
endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed bench for pc_redirect_unit with a scoreboard of expected pc/counter values.
// Combinational flags are checked with immediate assertions.
module tb_pc_redirect_unit;
    logic clk = 1'b0;
    logic reset;

    pc_redirect_unit_if #(.CNT_W(32)) bus ();

    pc_redirect_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] brc;
        logic [31:0] rdc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic st, input logic bv, input logic bt, input logic [31:0] bta,
                         input logic jv, input logic [31:0] jt,
                         input logic ex, input logic er, input logic [31:0] ep);
        bus.stall      = st;
        bus.br_valid   = bv;
        bus.br_taken   = bt;
        bus.br_target  = bta;
        bus.jmp_valid  = jv;
        bus.jmp_target = jt;
        bus.exc_req    = ex;
        bus.eret_req   = er;
        bus.epc        = ep;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic jump(input logic [31:0] t);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, t, 1'b0, 1'b0, 32'h0);
    endtask

    // Push the expected post-edge state, clock once, pop and compare
    task automatic tick(input string tag, input logic [31:0] p, input logic [31:0] b,
                        input logic [31:0] r);
        exp_t e;
        exp_t got;
        e.pc = p; e.brc = b; e.rdc = r;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        chk({tag, ".pc"},  bus.pc,           got.pc);
        chk({tag, ".brc"}, bus.br_taken_cnt, got.brc);
        chk({tag, ".rdc"}, bus.redirect_cnt, got.rdc);
    endtask

    initial begin
        reset = 1'b1;
        idle();
        tick("rst0", 32'h3000, 0, 0);
        tick("rst1", 32'h3000, 0, 0);
        chk("rst.kill", 32'(bus.kill_f), 0);
        chk("rst.ids",  32'(bus.in_delay_slot), 0);
        chk("rst.aerr", 32'(bus.addr_err), 0);
        reset = 1'b0;
        tick("seq1", 32'h3004, 0, 0);
        tick("seq2", 32'h3008, 0, 0);
        tick("seq3", 32'h300c, 0, 0);
        tick("seq4", 32'h3010, 0, 0);

        // not-taken then taken branch from 0x3010
        drive(1'b0, 1'b1, 1'b0, 32'h3040, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("nt.ids", 32'(bus.in_delay_slot), 1);
        tick("nt", 32'h3014, 0, 0);
        jump(32'h3010);
        chk("j.ids", 32'(bus.in_delay_slot), 1);
        tick("j1", 32'h3010, 1, 0);
        drive(1'b0, 1'b1, 1'b1, 32'h3040, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("tk.ids", 32'(bus.in_delay_slot), 1);
        tick("tk", 32'h3040, 2, 0);

        // stalled taken branch held three cycles
        jump(32'h3010);
        tick("j2", 32'h3010, 3, 0);
        drive(1'b1, 1'b1, 1'b1, 32'h3040, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick("st1", 32'h3010, 3, 0);
        tick("st2", 32'h3010, 3, 0);
        tick("st3", 32'h3010, 3, 0);
        drive(1'b0, 1'b1, 1'b1, 32'h3040, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick("st.rel", 32'h3040, 4, 0);

        // exception overrides stall and taken branch; REDIR ignores branch/jump
        jump(32'h3010);
        tick("j3", 32'h3010, 5, 0);
        drive(1'b1, 1'b1, 1'b1, 32'h3040, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("exc.kill", 32'(bus.kill_f), 1);
        chk("exc.ids",  32'(bus.in_delay_slot), 0);
        tick("exc", 32'h4180, 5, 1);
        drive(1'b0, 1'b1, 1'b1, 32'h3040, 1'b1, 32'h5000, 1'b0, 1'b0, 32'h0);
        chk("redir.ids",  32'(bus.in_delay_slot), 0);
        chk("redir.kill", 32'(bus.kill_f), 0);
        tick("redir", 32'h4184, 5, 1);

        // exc+eret together: exception wins, counted once
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h3020);
        tick("exc_eret", 32'h4180, 5, 2);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h3020);
        tick("eret1", 32'h3020, 5, 3);
        idle();
        tick("post_eret", 32'h3024, 5, 3);
        drive(1'b0, 1'b1, 1'b1, 32'h3040, 1'b0, 32'h0, 1'b0, 1'b1, 32'h3020);
        chk("eret.ids",  32'(bus.in_delay_slot), 0);
        chk("eret.kill", 32'(bus.kill_f), 1);
        tick("eret2", 32'h3020, 5, 4);
        idle();
        tick("post_eret2", 32'h3024, 5, 4);

        // address range / alignment boundaries
        jump(32'h7000);
        tick("j7000", 32'h7000, 6, 4);
        chk("aerr.7000", 32'(bus.addr_err), 1);
        jump(32'h3002);
        tick("j3002", 32'h3002, 7, 4);
        chk("aerr.3002", 32'(bus.addr_err), 1);
        jump(32'h6ffc);
        tick("j6ffc", 32'h6ffc, 8, 4);
        chk("aerr.6ffc", 32'(bus.addr_err), 0);
        idle();
        tick("inc7000", 32'h7000, 8, 4);
        chk("aerr.inc7000", 32'(bus.addr_err), 1);
        jump(32'h2ffc);
        tick("j2ffc", 32'h2ffc, 9, 4);
        chk("aerr.2ffc", 32'(bus.addr_err), 1);
        jump(32'h3000);
        tick("j3000", 32'h3000, 10, 4);
        chk("aerr.3000", 32'(bus.addr_err), 0);

        // reset while in REDIR with stall and exception pending
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        tick("exc2", 32'h4180, 10, 5);
        reset = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 32'h3040, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        tick("rst_mid", 32'h3000, 0, 0);
        reset = 1'b0;
        drive(1'b0, 1'b1, 1'b1, 32'h3040, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("rst_mid.ids", 32'(bus.in_delay_slot), 1);
        tick("rst_mid.br", 32'h3040, 1, 0);

        chk("sb.empty", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
